fetch_pc_unit: RTL and testbench

- Instruction-fetch front end of the pipelined MIPS core: owns the program counter and the IF/ID pipeline register.
- Drives the byte address into the combinational instruction memory and captures the returned word together with its PC.
- Accepts redirects for taken branches and jumps resolved in ID, and stalls from the hazard unit.
- Halts fetch on an illegal PC: misaligned, or outside the text window.

---
 rtl/fetch_pc_unit.sv | 104 ++++++++++
 tb/tb_fetch_pc_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: program counter, instruction-memory address and IF/ID register.
// Optional macro DELAY_SLOT_EN keeps the MIPS branch delay slot instead of flushing it on redirect.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h00400000,
  parameter logic [31:0] TEXT_BASE = 32'h00400000,
  parameter logic [31:0] TEXT_LAST = 32'h00404000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_if,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        fetch_fault
);

  typedef enum logic {
    RUNNING = 1'b0,
    FAULTED = 1'b1
  } fetchState_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic        valid;
  } ifId_t;

  localparam ifId_t IF_ID_BUBBLE = '0;

  fetchState_e state, stateNext;
  logic [31:0] pc, pcNext;
  logic [31:0] pcPlus4;
  logic        pcLegal;
  ifId_t       ifId, ifIdNext;
  ifId_t       fetchEntry;

  assign pcPlus4 = pc + 32'd4;
  assign pcLegal = (pc[1:0] == 2'b00) && (pc >= TEXT_BASE) && (pc <= TEXT_LAST);

  assign fetchEntry = '{instr: imem_data, pc: pc, pcPlus4: pcPlus4, valid: 1'b1};

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUNNING;
      pc    <= RESET_PC;
      ifId  <= IF_ID_BUBBLE;
    end else begin
      state <= stateNext;
      pc    <= pcNext;
      ifId  <= ifIdNext;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    stateNext = state;
    pcNext    = pc;
    ifIdNext  = ifId;

    unique case (state)
      FAULTED: begin
        ifIdNext = IF_ID_BUBBLE;
      end
      RUNNING: begin
        if (stall_if) begin
          ifIdNext = ifId;
        end else if (!pcLegal) begin
          // The word at an illegal PC is discarded and fetch freezes until reset.
          stateNext = FAULTED;
          ifIdNext  = IF_ID_BUBBLE;
        end else if (redirect) begin
          pcNext = redirect_target;
`ifdef DELAY_SLOT_EN
          ifIdNext = fetchEntry;
`else
          ifIdNext = IF_ID_BUBBLE;
`endif
        end else begin
          pcNext   = pcPlus4;
          ifIdNext = fetchEntry;
        end
      end
      default: begin
        stateNext = FAULTED;
        ifIdNext  = IF_ID_BUBBLE;
      end
    endcase
  end

  assign imem_addr      = pc;
  assign if_id_instr    = ifId.instr;
  assign if_id_pc       = ifId.pc;
  assign if_id_pc_plus4 = ifId.pcPlus4;
  assign if_id_valid    = ifId.valid;
  assign fetch_fault    = (state == FAULTED);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed table-driven bench for fetch_pc_unit; expectations follow DELAY_SLOT_EN like the design.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_if;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        fetch_fault;

  int numCompared = 0;
  int numMismatched = 0;

  fetch_pc_unit dut (
    .clk            (clk),
    .reset          (reset),
    .stall_if       (stall_if),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  // Program image: three known words, everything else reads as C0DE in the upper half and the low address bits below.
  function automatic logic [31:0] memWord(input logic [31:0] addr);
    case (addr)
      32'h00400000: memWord = 32'h20080001;
      32'h00400004: memWord = 32'h20090002;
      32'h00400008: memWord = 32'h010A5020;
      default:      memWord = {16'hC0DE, addr[15:0]};
    endcase
  endfunction

  assign imem_data = memWord(imem_addr);

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] target;
    logic [31:0] expAddr;
    logic [31:0] expInstr;
    logic [31:0] expPc;
    logic [31:0] expPc4;
    logic        expValid;
    logic        expFault;
  } vec_t;

  localparam int NUM_VECS = 23;
  vec_t vecs[NUM_VECS];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    numCompared++;
    if (actual !== expected) begin
      numMismatched++;
      $display("FAIL %s: got %08h expected %08h", name, actual, expected);
    end
  endtask

  // Drive inputs away from the edge, then sample 1 time unit after the rising edge.
  task automatic doStep(input logic r, input logic s, input logic d, input logic [31:0] t);
    @(negedge clk);
    reset = r;
    stall_if = s;
    redirect = d;
    redirect_target = t;
    @(posedge clk);
    #1;
  endtask

  task automatic checkAll(input string tag, input logic [31:0] eAddr, input logic [31:0] eInstr,
                          input logic [31:0] ePc, input logic [31:0] ePc4, input logic eValid,
                          input logic eFault);
    check({tag, ".imem_addr"}, imem_addr, eAddr);
    check({tag, ".instr"}, if_id_instr, eInstr);
    check({tag, ".pc"}, if_id_pc, ePc);
    check({tag, ".pc_plus4"}, if_id_pc_plus4, ePc4);
    check({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, eValid});
    check({tag, ".fault"}, {31'b0, fetch_fault}, {31'b0, eFault});
  endtask

  initial begin
    reset = 1'b1;
    stall_if = 1'b0;
    redirect = 1'b0;
    redirect_target = '0;

    //            rst   stall redir target        addr          instr         pc            pc+4          v     f
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h00400000, 32'h0,        32'h0,        32'h0,        1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h00400004, 32'h20080001, 32'h00400000, 32'h00400004, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h00400008, 32'h20090002, 32'h00400004, 32'h00400008, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h00400008, 32'h20090002, 32'h00400004, 32'h00400008, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h00400008, 32'h20090002, 32'h00400004, 32'h00400008, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0040000C, 32'h010A5020, 32'h00400008, 32'h0040000C, 1'b1, 1'b0};
`ifdef DELAY_SLOT_EN
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 32'h00400100, 32'h00400100, 32'hC0DE000C, 32'h0040000C, 32'h00400010, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 32'h00400200, 32'h00400100, 32'hC0DE000C, 32'h0040000C, 32'h00400010, 1'b1, 1'b0};
`else
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 32'h00400100, 32'h00400100, 32'h0,        32'h0,        32'h0,        1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 32'h00400200, 32'h00400100, 32'h0,        32'h0,        32'h0,        1'b0, 1'b0};
`endif
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h00400104, 32'hC0DE0100, 32'h00400100, 32'h00400104, 1'b1, 1'b0};
`ifdef DELAY_SLOT_EN
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h00400102, 32'h00400102, 32'hC0DE0104, 32'h00400104, 32'h00400108, 1'b1, 1'b0};
`else
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h00400102, 32'h00400102, 32'h0,        32'h0,        32'h0,        1'b0, 1'b0};
`endif
    // Misaligned PC: fault, then stall and redirect must both be ignored.
    vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h00400102, 32'h0,        32'h0,        32'h0,        1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h00400102, 32'h0,        32'h0,        32'h0,        1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 32'h00400000, 32'h00400102, 32'h0,        32'h0,        32'h0,        1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h00400102, 32'h0,        32'h0,        32'h0,        1'b0, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h00400102, 32'h0,        32'h0,        32'h0,        1'b0, 1'b1};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h00400000, 32'h0,        32'h0,        32'h0,        1'b0, 1'b0};
`ifdef DELAY_SLOT_EN
    vecs[16] = '{1'b0, 1'b0, 1'b1, 32'h00404000, 32'h00404000, 32'h20080001, 32'h00400000, 32'h00400004, 1'b1, 1'b0};
`else
    vecs[16] = '{1'b0, 1'b0, 1'b1, 32'h00404000, 32'h00404000, 32'h0,        32'h0,        32'h0,        1'b0, 1'b0};
`endif
    // Last legal word fetches valid; the next PC is just past the window.
    vecs[17] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h00404004, 32'hC0DE4000, 32'h00404000, 32'h00404004, 1'b1, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h00404004, 32'h0,        32'h0,        32'h0,        1'b0, 1'b1};
    vecs[19] = '{1'b1, 1'b1, 1'b1, 32'h00400200, 32'h00400000, 32'h0,        32'h0,        32'h0,        1'b0, 1'b0};
`ifdef DELAY_SLOT_EN
    vecs[20] = '{1'b0, 1'b0, 1'b1, 32'h003FFFFC, 32'h003FFFFC, 32'h20080001, 32'h00400000, 32'h00400004, 1'b1, 1'b0};
`else
    vecs[20] = '{1'b0, 1'b0, 1'b1, 32'h003FFFFC, 32'h003FFFFC, 32'h0,        32'h0,        32'h0,        1'b0, 1'b0};
`endif
    // Below-window PC faults even while stall is asserted in the following cycle.
    vecs[21] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h003FFFFC, 32'h0,        32'h0,        32'h0,        1'b0, 1'b1};
    vecs[22] = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h003FFFFC, 32'h0,        32'h0,        32'h0,        1'b0, 1'b1};

    for (int i = 0; i < NUM_VECS; i++) begin
      doStep(vecs[i].rst, vecs[i].stall, vecs[i].redir, vecs[i].target);
      checkAll($sformatf("vec%0d", i), vecs[i].expAddr, vecs[i].expInstr, vecs[i].expPc,
               vecs[i].expPc4, vecs[i].expValid, vecs[i].expFault);
    end

    // Reset in the very cycle an out-of-window PC would raise the fault.
    doStep(1'b1, 1'b0, 1'b0, 32'h0);
    doStep(1'b0, 1'b0, 1'b1, 32'h00404000);
    doStep(1'b0, 1'b0, 1'b0, 32'h0);
    check("edge.imem_addr", imem_addr, 32'h00404004);
    check("edge.fault_before", {31'b0, fetch_fault}, 32'h0);
    doStep(1'b1, 1'b1, 1'b1, 32'h00400300);
    checkAll("edgeReset", 32'h00400000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    doStep(1'b0, 1'b0, 1'b0, 32'h0);
    checkAll("afterReset", 32'h00400004, 32'h20080001, 32'h00400000, 32'h00400004, 1'b1, 1'b0);

    // A held stall on a legal PC must not fault and must keep IF/ID across several cycles.
    for (int k = 0; k < 3; k++) begin
      doStep(1'b0, 1'b1, 1'b0, 32'h0);
      checkAll($sformatf("longStall%0d", k), 32'h00400004, 32'h20080001, 32'h00400000, 32'h00400004,
               1'b1, 1'b0);
    end
    doStep(1'b0, 1'b0, 1'b0, 32'h0);
    checkAll("stallRelease", 32'h00400008, 32'h20090002, 32'h00400004, 32'h00400008, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
